// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: OAM DMA engine plus single-port arbiter for bram_oam.
//
// A CPU write to the DMA register copies OAM_BYTES bytes from the source page
// into OAM, one byte every CYCLES_PER_BYTE clocks, after START_DELAY idle clocks.
// The bram_oam port is shared with fixed priority DMA > PPU > CPU.
//
// Ports:
//   clk, rst_n                      clock (clk_4mhz), async active-low reset
//   mmio_a/din/wr, mmio_dout        DMA register write and readback
//   src_req/a/gnt, src_din          source bus read (data 1 clk after grant)
//   oam_a/din/wr, oam_dout          bram_oam port (1-clk read latency)
//   ppu_oam_rd/a, ppu_oam_dout      PPU read requester
//   cpu_oam_a/din/wr/rd, cpu_oam_dout  CPU read/write requester
//   dma_active                      transfer in progress
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transfer; CPU or PPU owns the OAM port
// DELAY | start delay after a register write, counting down delay_cnt
// XFER  | copying bytes; phase 0 read, 1 capture, 2 OAM write, rest idle
module oam_dma_ctrl #(
  parameter int          OAM_BYTES       = 160,
  parameter int          CYCLES_PER_BYTE = 4,
  parameter int          START_DELAY     = 4,
  parameter logic [15:0] DMA_REG_ADDR    = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mmio_a,
  input  logic [7:0]  mmio_din,
  input  logic        mmio_wr,
  output logic [7:0]  mmio_dout,
  output logic        src_req,
  output logic [15:0] src_a,
  input  logic        src_gnt,
  input  logic [7:0]  src_din,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_din,
  output logic        oam_wr,
  input  logic [7:0]  oam_dout,
  input  logic        ppu_oam_rd,
  input  logic [7:0]  ppu_oam_a,
  output logic [7:0]  ppu_oam_dout,
  input  logic [7:0]  cpu_oam_a,
  input  logic [7:0]  cpu_oam_din,
  input  logic        cpu_oam_wr,
  input  logic        cpu_oam_rd,
  output logic [7:0]  cpu_oam_dout,
  output logic        dma_active
);

  localparam int PW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [PW-1:0] PHASE_CAP  = PW'(1);
  localparam logic [PW-1:0] PHASE_WR   = PW'(2);
  localparam logic [DW-1:0] DELAY_LOAD = DW'(START_DELAY - 1);
  localparam logic [7:0]    LAST_INDEX = 8'(OAM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, XFER} state_t;

  state_t          state, state_next;
  logic [7:0]      index, index_next;
  logic [PW-1:0]   phase, phase_next;
  logic [DW-1:0]   delay_cnt, delay_next;
  logic [7:0]      dma_reg, page, data_latch;
  logic            lost_cpu, lost_ppu;
  logic            reg_wr, dma_wr;

  assign reg_wr = mmio_wr && (mmio_a == DMA_REG_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      index     <= '0;
      phase     <= '0;
      delay_cnt <= '0;
    end else begin
      state     <= state_next;
      index     <= index_next;
      phase     <= phase_next;
      delay_cnt <= delay_next;
    end
  end

  always_comb begin
    state_next = state;
    index_next = index;
    phase_next = phase;
    delay_next = delay_cnt;
    src_req    = 1'b0;
    dma_wr     = 1'b0;
    case (state)
      IDLE: ;
      DELAY: begin
        if (delay_cnt == '0) begin
          state_next = XFER;
          index_next = '0;
          phase_next = '0;
        end else begin
          delay_next = delay_cnt - DW'(1);
        end
      end
      XFER: begin
        src_req = (phase == '0);
        dma_wr  = (phase == PHASE_WR);
        if (phase == '0 && !src_gnt) begin
          phase_next = phase;  // stall until the source bus grants
        end else if (phase == PHASE_LAST) begin
          phase_next = '0;
          index_next = index + 8'd1;
          if (index == LAST_INDEX) state_next = IDLE;
        end else begin
          phase_next = phase + PW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    // A register write restarts from any state; the current cycle's OAM
    // write (if any) has already been presented and still lands.
    if (reg_wr) begin
      state_next = DELAY;
      delay_next = DELAY_LOAD;
      index_next = '0;
      phase_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_reg    <= 8'hFF;
      page       <= 8'h00;
      data_latch <= 8'h00;
    end else begin
      if (reg_wr) begin
        dma_reg <= mmio_din;
        // 0xE0-0xFF is echo RAM and aliases 0xC0-0xDF
        page    <= (mmio_din >= 8'hE0) ? (mmio_din - 8'h20) : mmio_din;
      end
      if (state == XFER && phase == PHASE_CAP) data_latch <= src_din;
    end
  end

  assign dma_active = (state != IDLE);
  assign src_a      = src_req ? {page, index} : 16'h0000;
  assign mmio_dout  = (mmio_a == DMA_REG_ADDR) ? dma_reg : 8'h00;

  always_comb begin
    oam_a   = cpu_oam_a;
    oam_din = cpu_oam_din;
    oam_wr  = cpu_oam_wr;
    if (dma_active) begin
      oam_a   = index;
      oam_din = data_latch;
      oam_wr  = dma_wr;
    end else if (ppu_oam_rd) begin
      oam_a  = ppu_oam_a;
      oam_wr = 1'b0;
    end
  end

  // Lost flags update only on a read, so a requester keeps seeing 8'hFF
  // until it issues a read that actually wins the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_cpu <= 1'b1;
      lost_ppu <= 1'b1;
    end else begin
      if (cpu_oam_rd) lost_cpu <= dma_active || ppu_oam_rd;
      if (ppu_oam_rd) lost_ppu <= dma_active;
    end
  end

  assign cpu_oam_dout = lost_cpu ? 8'hFF : oam_dout;
  assign ppu_oam_dout = lost_ppu ? 8'hFF : oam_dout;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  localparam int OAM_BYTES   = 160;
  localparam int START_DELAY = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mmio_a = 16'hFF46;
  logic [7:0]  mmio_din = 8'h00;
  logic        mmio_wr = 1'b0;
  logic [7:0]  mmio_dout;
  logic        src_req;
  logic [15:0] src_a;
  logic        src_gnt = 1'b1;
  logic [7:0]  src_din = 8'h00;
  logic [7:0]  oam_a, oam_din;
  logic        oam_wr;
  logic [7:0]  oam_dout = 8'h00;
  logic        ppu_oam_rd = 1'b0;
  logic [7:0]  ppu_oam_a = 8'h00;
  logic [7:0]  ppu_oam_dout;
  logic [7:0]  cpu_oam_a = 8'h00, cpu_oam_din = 8'h00;
  logic        cpu_oam_wr = 1'b0, cpu_oam_rd = 1'b0;
  logic [7:0]  cpu_oam_dout;
  logic        dma_active;

  oam_dma_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mmio_a(mmio_a), .mmio_din(mmio_din), .mmio_wr(mmio_wr), .mmio_dout(mmio_dout),
    .src_req(src_req), .src_a(src_a), .src_gnt(src_gnt), .src_din(src_din),
    .oam_a(oam_a), .oam_din(oam_din), .oam_wr(oam_wr), .oam_dout(oam_dout),
    .ppu_oam_rd(ppu_oam_rd), .ppu_oam_a(ppu_oam_a), .ppu_oam_dout(ppu_oam_dout),
    .cpu_oam_a(cpu_oam_a), .cpu_oam_din(cpu_oam_din), .cpu_oam_wr(cpu_oam_wr),
    .cpu_oam_rd(cpu_oam_rd), .cpu_oam_dout(cpu_oam_dout),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // Source memory and bram_oam models
  logic [7:0] src_mem [0:65535];
  logic [7:0] oam_mem [0:255];

  always @(posedge clk) if (src_req && src_gnt) src_din <= src_mem[src_a];

  always @(posedge clk) begin
    if (oam_wr) oam_mem[oam_a] <= oam_din;
    oam_dout <= oam_mem[oam_a];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] map_page(input logic [7:0] v);
    return (v >= 8'hE0) ? v - 8'h20 : v;
  endfunction

  // Scoreboard: granted reads and DMA writes must walk the page in order
  logic        mon_en = 1'b0;
  logic [7:0]  exp_page = 8'h00;
  int          rd_idx = 0;
  int          wr_idx = 0;
  logic [15:0] first_a = 16'h0000;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (src_req && src_gnt) begin
        if (rd_idx == 0) first_a = src_a;
        chk("src_a", 32'(src_a), 32'({exp_page, rd_idx[7:0]}));
        rd_idx++;
      end
      if (dma_active && oam_wr) begin
        chk("dma_wr_a", 32'(oam_a), 32'(wr_idx[7:0]));
        chk("dma_wr_d", 32'(oam_din), 32'(src_mem[{exp_page, wr_idx[7:0]}]));
        wr_idx++;
      end
    end
  end

  task automatic check_page(input string name, input logic [7:0] pg);
    int nbad;
    nbad = 0;
    for (int i = 0; i < OAM_BYTES; i++)
      if (oam_mem[i] !== src_mem[{pg, 8'(i)}]) nbad++;
    chk(name, 32'(nbad), 32'd0);
  endtask

  // mode 0: grant always; 1: random grant; 2: grant low 10 clks at index 7
  task automatic do_xfer(input logic [7:0] val, input int mode, output int len, output int stalls);
    int held, guard;
    logic [7:0] keep;
    held = 0; len = 0; stalls = 0; guard = 0;
    keep = oam_mem[8'hF0];
    exp_page = map_page(val); rd_idx = 0; wr_idx = 0; mon_en = 1'b1;
    @(posedge clk); #1;
    mmio_a = 16'hFF46; mmio_din = val; mmio_wr = 1'b1; src_gnt = 1'b1;
    @(posedge clk); #1;
    mmio_wr = 1'b0;
    cpu_oam_rd = 1'b1; ppu_oam_rd = 1'b1;
    cpu_oam_wr = 1'b1; cpu_oam_a = 8'hF0; cpu_oam_din = ~keep;
    chk("dma_reg_rb", 32'(mmio_dout), 32'(val));
    while (guard < 5000) begin
      if (mode == 1) src_gnt = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && src_req && src_a[7:0] == 8'd7 && held < 10) begin
        src_gnt = 1'b0; held++;
      end else src_gnt = 1'b1;
      @(negedge clk);
      if (!dma_active) break;
      len++;
      if (src_req && !src_gnt) stalls++;
      @(posedge clk); #1;
      guard++;
    end
    chk("xfer_done", 32'(guard < 5000), 32'd1);
    chk("cpu_rd_lost", 32'(cpu_oam_dout), 32'hFF);
    chk("ppu_rd_lost", 32'(ppu_oam_dout), 32'hFF);
    cpu_oam_rd = 1'b0; ppu_oam_rd = 1'b0; cpu_oam_wr = 1'b0; src_gnt = 1'b1;
    mon_en = 1'b0;
    chk("rd_count", 32'(rd_idx), 32'(OAM_BYTES));
    chk("wr_count", 32'(wr_idx), 32'(OAM_BYTES));
    @(posedge clk); #1;
    chk("cpu_wr_dropped", 32'(oam_mem[8'hF0]), 32'(keep));
    check_page("oam_contents", exp_page);
  endtask

  typedef struct {
    logic       ppu_rd;
    logic [7:0] ppu_a;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_a;
    logic [7:0] cpu_din;
    logic [7:0] exp_a;
    logic       exp_wr;
    logic [7:0] exp_din;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int len, stalls, guard, pre;
    logic seen;

    vecs[0] = '{1'b0, 8'h11, 1'b0, 1'b0, 8'h22, 8'h00, 8'h22, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h11, 1'b0, 1'b1, 8'h30, 8'hA5, 8'h30, 1'b1, 8'hA5};
    vecs[2] = '{1'b1, 8'h40, 1'b0, 1'b1, 8'h41, 8'h66, 8'h40, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 8'h9F, 1'b1, 1'b0, 8'h01, 8'h00, 8'h9F, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 8'h12, 1'b1, 1'b0, 8'h55, 8'h00, 8'h55, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 8'h13, 1'b0, 1'b1, 8'hFF, 8'h3C, 8'hFF, 1'b1, 8'h3C};

    for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
    for (int i = 0; i < OAM_BYTES; i++) src_mem[{8'hC1, 8'(i)}] = 8'(i) ^ 8'h5A;

    // Test 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_dma_active", 32'(dma_active), 32'd0);
    chk("rst_oam_wr", 32'(oam_wr), 32'd0);
    chk("rst_src_req", 32'(src_req), 32'd0);
    chk("rst_src_a", 32'(src_a), 32'd0);
    chk("rst_dma_reg", 32'(mmio_dout), 32'hFF);
    chk("rst_cpu_dout", 32'(cpu_oam_dout), 32'hFF);
    chk("rst_ppu_dout", 32'(ppu_oam_dout), 32'hFF);
    mmio_a = 16'hFF47;
    #1 chk("mmio_other_addr", 32'(mmio_dout), 32'h00);
    mmio_a = 16'hFF46;

    // Idle arbitration table
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      ppu_oam_rd = vecs[i].ppu_rd; ppu_oam_a = vecs[i].ppu_a;
      cpu_oam_rd = vecs[i].cpu_rd; cpu_oam_wr = vecs[i].cpu_wr;
      cpu_oam_a = vecs[i].cpu_a; cpu_oam_din = vecs[i].cpu_din;
      @(negedge clk);
      chk("arb_oam_a", 32'(oam_a), 32'(vecs[i].exp_a));
      chk("arb_oam_wr", 32'(oam_wr), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) chk("arb_oam_din", 32'(oam_din), 32'(vecs[i].exp_din));
    end
    @(posedge clk); #1;
    ppu_oam_rd = 1'b0; cpu_oam_rd = 1'b0; cpu_oam_wr = 1'b0;

    // Test 6: PPU beats a simultaneous CPU write; CPU read lost to the PPU
    @(posedge clk); #1;
    cpu_oam_wr = 1'b1; cpu_oam_a = 8'h10; cpu_oam_din = 8'h77;
    @(posedge clk); #1;
    ppu_oam_rd = 1'b1; ppu_oam_a = 8'h10; cpu_oam_din = 8'h99;
    @(posedge clk); #1;
    ppu_oam_rd = 1'b0; cpu_oam_wr = 1'b0; cpu_oam_rd = 1'b1;
    @(negedge clk);
    chk("ppu_rd_data", 32'(ppu_oam_dout), 32'h77);
    @(posedge clk); #1;
    ppu_oam_rd = 1'b1; ppu_oam_a = 8'h30; cpu_oam_a = 8'h30;
    @(negedge clk);
    chk("cpu_wr_dropped_idle", 32'(cpu_oam_dout), 32'h77);
    @(posedge clk); #1;
    ppu_oam_rd = 1'b0; cpu_oam_rd = 1'b0;
    @(negedge clk);
    chk("cpu_lost_to_ppu", 32'(cpu_oam_dout), 32'hFF);
    chk("ppu_rd_data2", 32'(ppu_oam_dout), 32'hA5);

    // Test 2: plain transfer from page C1
    do_xfer(8'hC1, 0, len, stalls);
    chk("len_c1", 32'(len), 32'd644);
    chk("oam0_c1", 32'(oam_mem[0]), 32'h5A);
    chk("oam159_c1", 32'(oam_mem[159]), 32'hC5);

    // Test 3: echo page
    do_xfer(8'hE3, 0, len, stalls);
    chk("echo_first_a", 32'(first_a), 32'hC300);
    chk("len_e3", 32'(len), 32'd644);

    // Test 4: 10-clock grant stall at index 7
    do_xfer(8'hC4, 2, len, stalls);
    chk("stall_count", 32'(stalls), 32'd10);
    chk("len_stall", 32'(len), 32'd654);

    // Test 5: restart with C2 while index 50 is being written
    @(posedge clk); #1;
    mmio_din = 8'hC1; mmio_wr = 1'b1; src_gnt = 1'b1;
    @(posedge clk); #1;
    mmio_wr = 1'b0;
    guard = 0;
    while (guard < 1000 && !(dma_active && oam_wr && oam_a == 8'd50)) begin
      @(posedge clk); #1; guard++;
    end
    chk("restart_reach", 32'(guard < 1000), 32'd1);
    mmio_din = 8'hC2; mmio_wr = 1'b1;
    @(posedge clk); #1;
    mmio_wr = 1'b0;
    chk("restart_inflight_wr", 32'(oam_mem[50]), 32'(src_mem[16'hC132]));
    len = 0; pre = 0; seen = 1'b0; guard = 0;
    while (guard < 2000) begin
      @(negedge clk);
      if (!dma_active) break;
      len++;
      if (src_req && !seen) begin
        seen = 1'b1;
        chk("restart_first_a", 32'(src_a), 32'hC200);
        chk("restart_delay", 32'(pre), 32'(START_DELAY));
      end
      if (!seen) pre++;
      @(posedge clk); #1; guard++;
    end
    chk("restart_len", 32'(len), 32'd644);
    @(posedge clk); #1;
    check_page("restart_contents", 8'hC2);

    // Randomized transfers: length is the nominal time plus grant stalls
    for (int t = 0; t < 4; t++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (t == 3) v = 8'($urandom_range(8'hE0, 8'hFF));
      do_xfer(v, 1, len, stalls);
      chk("rand_len", 32'(len), 32'(START_DELAY + OAM_BYTES * 4 + stalls));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
